serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 118 +++++++++++
 tb/tb_serial_adder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add stage per clock, LSB first, with a registered
// carry. Three-state controller (IDLE -> RUN for WIDTH cycles -> DONE).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             load;
  logic             step;
  logic             last_bit;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             c_bit;

  // Single full-add stage on the operand LSBs and the registered carry.
  always_comb begin
    s_bit = a_sr[0] ^ b_sr[0] ^ carry;
    c_bit = (a_sr[0] & b_sr[0]) | (b_sr[0] & carry) | (carry & a_sr[0]);
  end

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and datapath control strobes.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_bit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operand/result shift registers, carry register and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (step) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      sum_sr <= {s_bit, sum_sr[WIDTH-1:1]};
      carry  <= c_bit;
      cnt    <= cnt + CW'(1);
    end
  end

  // The carry register holds the final carry-out once RUN has finished.
  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sum  = sum_sr;
  assign cout = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks for serial_adder at WIDTH=8.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vcin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands with start for one edge, then scrambles the inputs.
  task automatic start_op(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    a     = va;
    b     = vb;
    cin   = vc;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = $urandom_range(0, 255);
    b     = $urandom_range(0, 255);
    cin   = $urandom_range(0, 1);
  endtask

  // Counts edges since the accept edge until done is seen; lat = -1 on timeout.
  task automatic wait_done(input int already, output int lat);
    lat = -1;
    for (int n = already + 1; n <= WIDTH + 4; n++) begin
      tick();
      check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    logic [8:0]  full;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rc;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[8] = '{8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0};
    vecs[9] = '{8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    tick();
    tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_sum",  {24'd0, sum},  32'd0);
    check("reset_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;
    tick();

    // Table of single operations, each separated by an idle cycle.
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].va, vecs[i].vb, vecs[i].vcin);
      check("vec_busy_first_run", {31'd0, busy}, 32'd1);
      wait_done(0, lat);
      check("vec_latency", lat, WIDTH);
      check("vec_sum",  {24'd0, sum},  {24'd0, vecs[i].exp_sum});
      check("vec_cout", {31'd0, cout}, {31'd0, vecs[i].exp_cout});
      tick();
      check("vec_done_one_cycle", {31'd0, done}, 32'd0);
      check("vec_idle_not_busy", {31'd0, busy}, 32'd0);
      tick();
      tick();
      check("vec_sum_hold",  {24'd0, sum},  {24'd0, vecs[i].exp_sum});
      check("vec_cout_hold", {31'd0, cout}, {31'd0, vecs[i].exp_cout});
    end

    // Start pulsed during the third RUN cycle must be ignored.
    start_op(8'h10, 8'h20, 1'b0);
    tick();
    tick();
    a     = 8'hAA;
    b     = 8'h55;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(3, lat);
    check("ignore_latency", lat, WIDTH);
    check("ignore_sum",  {24'd0, sum},  32'h30);
    check("ignore_cout", {31'd0, cout}, 32'd0);
    for (int n = 0; n < WIDTH + 2; n++) begin
      tick();
      check("ignore_single_done", {31'd0, done}, 32'd0);
    end

    // Back-to-back: start held through DONE restarts RUN directly.
    start_op(8'h5A, 8'h3C, 1'b0);
    wait_done(0, lat);
    check("b2b_first_latency", lat, WIDTH);
    check("b2b_first_sum",  {24'd0, sum},  32'h96);
    check("b2b_first_cout", {31'd0, cout}, 32'd0);
    start_op(8'h01, 8'h02, 1'b1);
    check("b2b_no_idle", {31'd0, busy}, 32'd1);
    wait_done(0, lat);
    check("b2b_second_latency", lat, WIDTH);
    check("b2b_second_sum",  {24'd0, sum},  32'h04);
    check("b2b_second_cout", {31'd0, cout}, 32'd0);
    tick();

    // Reset asserted during the fourth RUN cycle aborts the operation.
    start_op(8'hFF, 8'hFF, 1'b1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum",  {24'd0, sum},  32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    for (int n = 0; n < WIDTH + 2; n++) begin
      tick();
      check("abort_no_done", {31'd0, done | busy}, 32'd0);
    end
    start_op(8'h80, 8'h80, 1'b0);
    wait_done(0, lat);
    check("post_reset_latency", lat, WIDTH);
    check("post_reset_sum",  {24'd0, sum},  32'h00);
    check("post_reset_cout", {31'd0, cout}, 32'd1);
    tick();

    // Random operands, mixing idle gaps and back-to-back starts.
    for (int i = 0; i < 1000; i++) begin
      ra   = $urandom_range(0, 255);
      rb   = $urandom_range(0, 255);
      rc   = $urandom_range(0, 1);
      full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      start_op(ra, rb, rc);
      wait_done(0, lat);
      check("rand_latency", lat, WIDTH);
      check("rand_sum",  {24'd0, sum},  {24'd0, full[7:0]});
      check("rand_cout", {31'd0, cout}, {31'd0, full[8]});
      if ($urandom_range(0, 1) == 0) begin
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
